clk_profile_seq: RTL
====================

Name: clk_profile_seq

Overview:
Sequencer for the programmable clock generator (period/duty divider). It holds a small table of (period, duty, dwell) profiles and drives the generator's period/duty inputs from it. New settings are applied only at generator cycle boundaries, so clock changes are glitch-free. Sits between the control/register logic and the clock generator, all in the `clk` domain.

Parameters:
DEPTH, 8, number of profile table entries (power of 2)
AW, 3, table address width (log2 DEPTH)
DWELL_W, 8, width of the dwell field (generator output cycles per entry)

Ports:
clk  in  1  system clock; also clocks the generator
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  table write strobe
cfg_addr  in  AW  table write address
cfg_period  in  4  period field written to the table
cfg_duty  in  2  duty field written to the table
cfg_dwell  in  DWELL_W  dwell field written to the table
last_idx  in  AW  index of the final entry in the sequence
loop_en  in  1  1 = wrap from last_idx back to entry 0
start  in  1  1-cycle start request
stop  in  1  1-cycle stop request
gen_clk_out  in  1  clk_out fed back from the generator (synchronous to clk)
period  out  4  to generator period input
duty  out  2  to generator duty input
busy  out  1  high in RUN or STOPPING
done  out  1  1-cycle pulse on normal completion or stop
err  out  1  sticky: a table entry with period==0 was reached
cur_idx  out  AW  index of the entry currently applied

Behaviour:
- Reset (async, rst_n=0): period=0, duty=0, busy=0, done=0, err=0, cur_idx=0, state=IDLE, dwell count=0, edge register=0. Table contents are not reset.
- Table: DEPTH x {period[3:0], duty[1:0], dwell}. Writes are synchronous and allowed at any time. Reads are combinational. A write and a read of the same entry in the same cycle: the applied value is the pre-write value.
- Boundary detect: fall = gen_q & ~gen_clk_out, where gen_q is gen_clk_out registered.
- Dwell: an entry is held for max(dwell,1) falling edges of gen_clk_out.
- States: IDLE, RUN, STOPPING.
- IDLE:
  - start=1 and stop=0 -> next cycle: period/duty = entry0, cur_idx=0, err cleared, count=0, busy=1, state RUN. Apply latency is 1 cycle.
  - If entry0.period==0, nothing is applied; err=1 and the block stays in IDLE.
  - start and stop asserted in the same cycle: stop wins, start is ignored.
- RUN: on fall, count++. When count reaches max(dwell,1)-1 on a fall, advance to the next entry.
  - Next entry: idx+1, or 0 if idx==last_idx and loop_en=1.
  - Advance: apply the next entry in the cycle after the fall, reset count, update cur_idx.
  - If idx==last_idx and loop_en=0: done pulse, go to IDLE (final settings per macro).
  - If the next entry has period==0: err=1, done not pulsed, go to IDLE.
  - start while busy is ignored.
- stop in RUN -> STOPPING. At the next fall: done pulse, go to IDLE. A stop in STOPPING or IDLE is ignored.
- last_idx and loop_en are sampled at each advance; they may change mid-run.
- last_idx >= DEPTH is impossible by width. cur_idx wraps modulo DEPTH only via loop_en.
- rst_n asserted mid-run: immediate return to reset values.

Optional Feature:
CLKSEQ_PARK_EN
- Defined: on entering IDLE (completion, stop or err), period and duty are driven to 0, parking the generator output low.
- Undefined: period and duty hold the last applied entry, so the generator keeps running.

Decomposition:
- Package clk_seq_pkg:
  - state enum {IDLE, RUN, STOPPING}
  - profile entry struct {period, duty, dwell}
  - constants PERIOD_W=4, DUTY_W=2
- One natural sub-module, clk_seq_table: the DEPTH-entry register file with one write port and one combinational read port.

Test Plan:
- Load e0={1,00,2}, e1={2,01,1}, last_idx=1, loop_en=0, start; bench drives gen_clk_out with 5-low/5-high cycles -> period=1, duty=0 one cycle after start; switch to {2,01} the cycle after the 2nd fall; done pulse after the next fall; busy=0.
- Same table with loop_en=1 -> cur_idx sequence 0,0,1,0,0,1... per falls; stop -> done at the next fall, busy drops.
- e0={3,10,0} (dwell 0) -> entry held for exactly 1 fall.
- e1.period=0 -> err=1 after e0's dwell expires, no done pulse; the next start clears err.
- start and stop in the same cycle from IDLE -> stays IDLE, busy=0. Rewrite entry1 while e0 is active -> the new entry1 values are applied.
- rst_n low mid-RUN -> all outputs 0 immediately. Repeat the first scenario with and without CLKSEQ_PARK_EN -> final period 0 vs 2.

Source files
------------

// File: rtl/clk_seq_pkg.sv
// Shared types for the clock profile sequencer: FSM states, the generator
// setting carried by each table entry, and a validity helper.
package clk_seq_pkg;

  localparam int PERIOD_W = 4;
  localparam int DUTY_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } seq_state_e;

  // Generator setting part of a profile entry; the dwell field is added by
  // the users of this type because its width is a module parameter.
  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUTY_W-1:0]   duty;
  } gen_cfg_t;

  // A zero period cannot be generated, so such an entry ends the sequence.
  function automatic logic cfg_valid(input gen_cfg_t c);
    return c.period != '0;
  endfunction

endpackage

// File: rtl/clk_seq_table.sv
// Profile table: DEPTH entries of {period, duty, dwell}, one synchronous
// write port and one combinational read port. Contents are not reset.
module clk_seq_table
  import clk_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  gen_cfg_t           wcfg,
  input  logic [DWELL_W-1:0] wdwell,
  input  logic [AW-1:0]      raddr,
  output gen_cfg_t           rcfg,
  output logic [DWELL_W-1:0] rdwell
);

  typedef struct packed {
    gen_cfg_t           cfg;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  entry_t mem [DEPTH];

  // Table write; a same-cycle read of the entry still returns the old value.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= '{cfg: wcfg, dwell: wdwell};
    end
  end

  assign rcfg   = mem[raddr].cfg;
  assign rdwell = mem[raddr].dwell;

endmodule

// File: rtl/clk_profile_seq.sv
// Clock profile sequencer: steps the clock generator through a table of
// (period, duty, dwell) entries, switching settings only right after a
// falling edge of the generator output so changes are glitch-free.
// Optional build macro CLKSEQ_PARK_EN: when defined, period/duty are driven
// to 0 whenever the sequence returns to IDLE (generator parked low);
// otherwise the last applied setting is held.
module clk_profile_seq
  import clk_seq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [DUTY_W-1:0]   cfg_duty,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  input  logic [AW-1:0]       last_idx,
  input  logic                loop_en,
  input  logic                start,
  input  logic                stop,
  input  logic                gen_clk_out,
  output logic [PERIOD_W-1:0] period,
  output logic [DUTY_W-1:0]   duty,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [AW-1:0]       cur_idx
);

`ifdef CLKSEQ_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  seq_state_e         state_q, state_d;
  gen_cfg_t           cfg_q, cfg_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               gen_q;
  logic               fall;
  logic [AW-1:0]      nxt_idx;
  logic [AW-1:0]      rd_addr;
  logic [DWELL_W-1:0] dwell_last;
  gen_cfg_t           rd_cfg;
  logic [DWELL_W-1:0] rd_dwell;
  gen_cfg_t           wr_cfg;

  assign wr_cfg = '{period: cfg_period, duty: cfg_duty};

  clk_seq_table #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .DWELL_W (DWELL_W)
  ) u_table (
    .clk    (clk),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wcfg   (wr_cfg),
    .wdwell (cfg_dwell),
    .raddr  (rd_addr),
    .rcfg   (rd_cfg),
    .rdwell (rd_dwell)
  );

  // A generator cycle boundary is a falling edge of its output.
  assign fall = gen_q & ~gen_clk_out;

  // Wrap to entry 0 only when looping; otherwise the index simply increments
  // (the last-entry case terminates before this value is used).
  assign nxt_idx = (idx_q == last_idx && loop_en) ? '0 : idx_q + 1'b1;

  // Single read port: entry 0 while idle (start), else the next entry.
  assign rd_addr = (state_q == IDLE) ? '0 : nxt_idx;

  // Dwell of 0 behaves as 1: the final count value is max(dwell,1)-1.
  assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;

  // Register the generator output for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_q <= 1'b0;
    end else begin
      gen_q <= gen_clk_out;
    end
  end

  // Sequencer state and applied-setting registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start, dwell counting, advance, termination and stop.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (!cfg_valid(rd_cfg)) begin
            err_d = 1'b1;
          end else begin
            cfg_d   = rd_cfg;
            dwell_d = rd_dwell;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (stop) begin
          state_d = STOPPING;
        end else if (fall) begin
          if (cnt_q != dwell_last) begin
            cnt_d = cnt_q + 1'b1;
          end else if (idx_q == last_idx && !loop_en) begin
            done_d  = 1'b1;
            state_d = IDLE;
            if (PARK) cfg_d = '0;
          end else if (!cfg_valid(rd_cfg)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            if (PARK) cfg_d = '0;
          end else begin
            cfg_d   = rd_cfg;
            dwell_d = rd_dwell;
            idx_d   = nxt_idx;
            cnt_d   = '0;
          end
        end
      end
      STOPPING: begin
        if (fall) begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (PARK) cfg_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period  = cfg_q.period;
  assign duty    = cfg_q.duty;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;
  assign cur_idx = idx_q;

endmodule
